mem_arbiter: RTL

// - Shares the single block-wide main memory port between two L2-side requesters (port 0, port 1).
// - Round-robin arbitration; exactly one memory operation outstanding at a time.
// - Sits between the L2 cache miss/writeback paths and the main memory model.
// - Registers the granted request and returns the memory block plus a one-cycle ready pulse to the winner.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one main-memory port between two L2-side requesters (port 0 and
//   port 1). Round-robin arbitration, one memory operation outstanding at a
//   time. The granted request is latched, driven to memory until mem_ready,
//   and completed with a one-cycle reqN_ready pulse to the winner.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   reqN_read/_write         N=0,1 request level, held until reqN_ready
//   reqN_addr/_wdata         request address and write block
//   reqN_rdata               read block of the last completion for port N
//   reqN_ready               one-cycle completion pulse
//   reqN_err                 timeout completion flag, pulses with reqN_ready
//   mem_addr/_wdata          latched request towards memory
//   mem_read/_write          memory operation level, high only in BUSY
//   mem_rdata/_ready         memory response block and completion pulse
//   busy                     1 while an operation is in BUSY or RESP
//   grant_id                 port owning the current/last operation
//
// Build option
//   MEM_ARB_TIMEOUT_EN       when defined, a BUSY watchdog of TIMEOUT_CYCLES
//                            completes the operation with reqN_err=1 and
//                            zero read data; otherwise BUSY waits forever.

module mem_arbiter #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned BLOCK_SIZE     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req0_read,
   input  logic                             req0_write,
   input  logic [ADDR_WIDTH-1:0]            req0_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req0_wdata,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] req0_rdata,
   output logic                             req0_ready,
   output logic                             req0_err,
   input  logic                             req1_read,
   input  logic                             req1_write,
   input  logic [ADDR_WIDTH-1:0]            req1_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req1_wdata,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] req1_rdata,
   output logic                             req1_ready,
   output logic                             req1_err,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
   output logic                             mem_read,
   output logic                             mem_write,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
   input  logic                             mem_ready,
   output logic                             busy,
   output logic                             grant_id
);

   localparam int unsigned BW = BLOCK_SIZE * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic                  id_q, id_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BW-1:0]         wdata_q, wdata_d;
   logic [BW-1:0]         rdata0_q, rdata0_d;
   logic [BW-1:0]         rdata1_q, rdata1_d;
   logic                  act0, act1;
   logic                  timeout;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   // Held at zero outside BUSY, so every BUSY entry starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_q != S_BUSY) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Fires in the last allowed BUSY cycle so RESP follows exactly
   // TIMEOUT_CYCLES BUSY cycles.
   assign timeout = (state_q == S_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   assign act0 = req0_read | req0_write;
   assign act1 = req1_read | req1_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      wr_d     = wr_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      unique case (state_q)
         S_IDLE: begin
            if (act0 | act1) begin
               // On a tie the port that did not win last time is served.
               id_d    = (act0 & act1) ? ~last_q : act1;
               last_d  = id_d;
               addr_d  = id_d ? req1_addr  : req0_addr;
               wdata_d = id_d ? req1_wdata : req0_wdata;
               // read and write together are treated as a write
               wr_d    = id_d ? req1_write : req0_write;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            // A memory response in the timeout cycle takes priority.
            if (mem_ready) begin
               err_d   = 1'b0;
               state_d = S_RESP;
               if (id_q) rdata1_d = wr_q ? '0 : mem_rdata;
               else      rdata0_d = wr_q ? '0 : mem_rdata;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_RESP;
               if (id_q) rdata1_d = '0;
               else      rdata0_d = '0;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign grant_id   = id_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_read   = (state_q == S_BUSY) & ~wr_q;
   assign mem_write  = (state_q == S_BUSY) & wr_q;
   assign req0_ready = (state_q == S_RESP) & ~id_q;
   assign req1_ready = (state_q == S_RESP) & id_q;
   assign req0_err   = req0_ready & err_q;
   assign req1_err   = req1_ready & err_q;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;

endmodule
